instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 clock  in  1  single clock; all state changes on posedge clock.
REQ-004 resetN  in  1  reset, asynchronous, active-low.
REQ-005 available  in  1  decode stage can accept an instruction (ROB not full).
REQ-006 decodePulse  out  1  one-cycle strobe; decode samples instr/pcNumber on its rising edge.
REQ-007 instr  out  32  instruction word presented with decodePulse.
REQ-008 pcNumber  out  32  address of instr.
REQ-009 memReq  out  1  instruction memory read request, level-held until memDone.
REQ-010 memAddr  out  32  word-aligned read address, stable while memReq high.
REQ-011 memDone  in  1  one-cycle completion; memData valid in same cycle.
REQ-012 memData  in  32  returned instruction word.
REQ-013 redirectValid  in  1  one-cycle PC redirect (jump/branch resolution).
REQ-014 redirectPc  in  32  new fetch address, valid with redirectValid.

Function
REQ-015 Fetch FSM SHALL have states IDLE, REQ, DRAIN.
REQ-016 IDLE->REQ when count + 0 in-flight < BUF_DEPTH and no redirectValid; memReq=1, memAddr=fetchPc.
REQ-017 REQ, memDone, no redirect: push {fetchPc, memData}, fetchPc += 4 (mod 2^32 wrap), go IDLE.
REQ-018 At most one memory request outstanding; memAddr/memReq SHALL NOT change in REQ or DRAIN until memDone.
REQ-019 redirectValid in IDLE: fetchPc <= redirectPc, buffer flushed, stay IDLE.
REQ-020 redirectValid in REQ without memDone: fetchPc <= redirectPc, flush, go DRAIN.
REQ-021 DRAIN: memReq held with old address; on memDone data discarded, go IDLE; further redirect in DRAIN updates fetchPc only.
REQ-022 redirectValid and memDone same cycle: returned data discarded, fetchPc <= redirectPc, flush, go IDLE.
REQ-023 Dispatch: if decodePulse was 0 last cycle, buffer non-empty, available=1, redirectValid=0 -> decodePulse=1, instr/pcNumber <= head, pop.
REQ-024 decodePulse SHALL be 0 in the cycle after any pulse (max one instruction per two cycles).
REQ-025 instr and pcNumber SHALL hold their values between pulses.
REQ-026 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-027 Buffer never overflows: request issued only when count < BUF_DEPTH at issue time, no other push source.
REQ-028 Flush sets count=0 and discards any same-cycle push; no pulse issued in a flush cycle.
REQ-029 available=0 stalls dispatch only; fetch continues until buffer full.

Reset
REQ-030 resetN low asynchronously: state IDLE, fetchPc=RESET_PC, count=0, decodePulse=0, instr=0, pcNumber=0, memReq=0, memAddr=RESET_PC.
REQ-031 Reset mid-request abandons it; a memDone arriving after reset release while IDLE SHALL be ignored.
REQ-032 First memReq SHALL assert in the first clock edge after resetN deasserts.

Structure
REQ-033 Shared package cpu_pkg holds RESET_PC default, XLEN=32, NOP=32'h0000_0013, fetch FSM state encoding.
REQ-034 One sub-module fetch_buffer: synchronous FIFO {pc,instr}, push/pop/flush, count, full/empty.

Verification
REQ-035 Reset, memDone 2 cycles after each memReq, data 0x00500093/0x00100113, available=1 -> pulses with pcNumber 0x0 then 0x4, correct instr, pulses >=2 cycles apart.
REQ-036 available=0 for 20 cycles -> exactly BUF_DEPTH fetches then memReq stays 0; raise available -> 4 pulses in order, PCs 0x0..0xC.
REQ-037 redirectValid to 0x100 while in REQ -> memReq held to memDone, that data never dispatched; next memAddr=0x100, next pcNumber=0x100.
REQ-038 redirectValid and memDone same cycle, redirectPc=0x200 -> no pulse of returned word; next memAddr=0x200.
REQ-039 fetchPc 0xFFFFFFFC fetched -> next memAddr 0x00000000.
REQ-040 resetN low mid-REQ, late memDone after release -> all outputs at reset values, stray data not buffered, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Fetch FSM encoding and the buffered {pc, instr} entry live here.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} pairs.
// Flush clears it and wins over a same-cycle push or pop.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      resetN,
   input  logic                      push,
   input  logic [XLEN-1:0]           pushPc,
   input  logic [XLEN-1:0]           pushInstr,
   input  logic                      pop,
   input  logic                      flush,
   output logic [XLEN-1:0]           headPc,
   output logic [XLEN-1:0]           headInstr,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t     mem [DEPTH];
   logic [AW-1:0]    rdPtr;
   logic [AW-1:0]    wrPtr;
   logic             doPush;
   logic             doPop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign doPush    = push && !flush;
   assign doPop     = pop && !empty && !flush;
   assign headPc    = mem[rdPtr].pc;
   assign headInstr = mem[rdPtr].instr;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + AW'(1);
         if (doPop)
            rdPtr <= rdPtr + AW'(1);
         unique case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (doPush)
         mem[wrPtr] <= {pushPc, pushInstr};
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory read, a small buffer,
// and a rate-limited dispatch strobe toward decode.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        available,
   output logic        decodePulse,
   output logic [31:0] instr,
   output logic [31:0] pcNumber,
   output logic        memReq,
   output logic [31:0] memAddr,
   input  logic        memDone,
   input  logic [31:0] memData,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t    state;
   fetch_state_t    stateNext;
   logic [31:0]     fetchPc;
   logic [31:0]     fetchPcNext;
   logic            issue;
   logic            push;
   logic            pop;
   logic            flush;
   logic            bufFull;
   logic            bufEmpty;
   logic [CW-1:0]   bufCount;
   logic [31:0]     headPc;
   logic [31:0]     headInstr;

   assign memReq = (state != IDLE);
   assign pop    = !decodePulse && !bufEmpty && available && !redirectValid;

   always_comb begin
      stateNext   = state;
      fetchPcNext = fetchPc;
      issue       = 1'b0;
      push        = 1'b0;
      flush       = 1'b0;
      if (redirectValid) begin
         fetchPcNext = redirectPc;
         flush       = 1'b1;
      end
      unique case (state)
         IDLE: begin
            if (!redirectValid && (bufCount < CW'(BUF_DEPTH))) begin
               stateNext = REQ;
               issue     = 1'b1;
            end
         end
         REQ: begin
            if (memDone) begin
               stateNext = IDLE;
               if (!redirectValid) begin
                  push        = !bufFull;
                  fetchPcNext = fetchPc + 32'd4;
               end
            end else if (redirectValid) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            // The stale word is swallowed here; only the new PC survives.
            if (memDone)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         fetchPc <= RESET_PC;
         memAddr <= RESET_PC;
      end else begin
         state   <= stateNext;
         fetchPc <= fetchPcNext;
         if (issue)
            memAddr <= fetchPc;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         decodePulse <= 1'b0;
         instr       <= '0;
         pcNumber    <= '0;
      end else begin
         decodePulse <= pop;
         if (pop) begin
            instr    <= headInstr;
            pcNumber <= headPc;
         end
      end
   end

   fetch_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clock     (clock),
      .resetN    (resetN),
      .push      (push),
      .pushPc    (fetchPc),
      .pushInstr (memData),
      .pop       (pop),
      .flush     (flush),
      .headPc    (headPc),
      .headInstr (headInstr),
      .count     (bufCount),
      .full      (bufFull),
      .empty     (bufEmpty)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of
// expected {pc, instr} dispatches and a 2-cycle memory responder.
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        resetN;
   logic        available;
   logic        decodePulse;
   logic [31:0] instr;
   logic [31:0] pcNumber;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memDone = 1'b0;
   logic [31:0] memData = '0;
   logic        redirectValid;
   logic [31:0] redirectPc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;
   exp_t sb[$];

   int          respBudget = 0;
   int          respUsed   = 0;
   int          injReq     = 0;
   int          injSeen    = 0;
   int          waitC      = 0;
   logic [31:0] injData    = '0;
   logic        prevPulse  = 1'b0;

   instruction_fetch dut (
      .clock         (clock),
      .resetN        (resetN),
      .available     (available),
      .decodePulse   (decodePulse),
      .instr         (instr),
      .pcNumber      (pcNumber),
      .memReq        (memReq),
      .memAddr       (memAddr),
      .memDone       (memDone),
      .memData       (memData),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memword(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h0010_0113;
         default: return a ^ 32'h1357_0013;
      endcase
   endfunction

   function automatic logic [31:0] w1(input logic x);
      return {31'b0, x};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = memword(pc);
      sb.push_back(e);
   endtask

   task automatic grant(input int n);
      respBudget = respUsed + n;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirectValid = 1'b1;
      redirectPc    = pc;
      cyc(1);
      redirectValid = 1'b0;
   endtask

   task automatic redir_done(input logic [31:0] pc, input logic [31:0] d);
      injData = d;
      injReq++;
      redirect(pc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pulse"}, w1(decodePulse), 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_pc"}, pcNumber, 32'd0);
      chk({tag, "_memReq"}, w1(memReq), 32'd0);
      chk({tag, "_memAddr"}, memAddr, 32'd0);
   endtask

   // Memory model: answers each request two cycles after it rises.
   always @(negedge clock) begin
      memDone = 1'b0;
      if (injReq != injSeen) begin
         injSeen = injReq;
         memDone = 1'b1;
         memData = injData;
         waitC   = 0;
      end else if (resetN && memReq && respUsed < respBudget) begin
         waitC++;
         if (waitC >= 2) begin
            memDone = 1'b1;
            memData = memword(memAddr);
            respUsed++;
            waitC   = 0;
         end
      end else begin
         waitC = 0;
      end
   end

   always @(negedge clock) begin
      if (resetN !== 1'b1) begin
         prevPulse = 1'b0;
      end else begin
         if (decodePulse === 1'b1) begin
            chk("pulseGap", w1(prevPulse), 32'd0);
            chk("pulseExpected", w1(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("dispatchPc", pcNumber, e.pc);
               chk("dispatchInstr", instr, e.ins);
            end
         end
         prevPulse = decodePulse;
      end
   end

   initial begin
      int base;
      resetN        = 1'b0;
      available     = 1'b1;
      redirectValid = 1'b0;
      redirectPc    = '0;
      cyc(3);
      chk_reset_outputs("rst");

      // Basic two-instruction fetch and dispatch
      grant(2);
      expect_pc(32'h0);
      expect_pc(32'h4);
      resetN = 1'b1;
      cyc(1);
      chk("firstReq", w1(memReq), 32'd1);
      chk("firstAddr", memAddr, 32'h0);
      cyc(14);
      chk("basicDrain", 32'(sb.size()), 32'd0);
      chk("basicNextAddr", memAddr, 32'h8);

      // Decode stalled: buffer fills then fetch stops
      resetN    = 1'b0;
      available = 1'b0;
      cyc(2);
      base = respUsed;
      grant(4);
      resetN = 1'b1;
      cyc(20);
      chk("fullNoReq", w1(memReq), 32'd0);
      chk("fullFetches", 32'(respUsed - base), 32'd4);
      chk("fullLastAddr", memAddr, 32'hC);
      expect_pc(32'h0);
      expect_pc(32'h4);
      expect_pc(32'h8);
      expect_pc(32'hC);
      available = 1'b1;
      cyc(16);
      chk("fullDrain", 32'(sb.size()), 32'd0);
      chk("fullResumeReq", w1(memReq), 32'd1);
      chk("fullResumeAddr", memAddr, 32'h10);

      // Redirect while a request is outstanding
      resetN = 1'b0;
      cyc(2);
      grant(1);
      expect_pc(32'h0);
      resetN = 1'b1;
      cyc(8);
      chk("preRedirDrain", 32'(sb.size()), 32'd0);
      chk("preRedirAddr", memAddr, 32'h4);
      redirect(32'h100);
      chk("drainReq", w1(memReq), 32'd1);
      chk("drainAddr", memAddr, 32'h4);
      cyc(3);
      chk("drainHoldReq", w1(memReq), 32'd1);
      chk("drainHoldAddr", memAddr, 32'h4);
      injData = 32'hDEAD_BEEF;
      injReq++;
      cyc(1);
      grant(2);
      expect_pc(32'h100);
      expect_pc(32'h104);
      cyc(1);
      chk("redirReq", w1(memReq), 32'd1);
      chk("redirAddr", memAddr, 32'h100);
      cyc(12);
      chk("redirDrain", 32'(sb.size()), 32'd0);

      // Redirect coincident with memDone
      redir_done(32'h200, 32'hBAD0_0000);
      grant(1);
      expect_pc(32'h200);
      cyc(1);
      chk("coincReq", w1(memReq), 32'd1);
      chk("coincAddr", memAddr, 32'h200);
      cyc(8);
      chk("coincDrain", 32'(sb.size()), 32'd0);

      // PC wraps past the top of the address space
      redir_done(32'hFFFF_FFFC, 32'hBAD1_1111);
      grant(2);
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0);
      cyc(4);
      chk("wrapAddr", memAddr, 32'h0);
      cyc(8);
      chk("wrapDrain", 32'(sb.size()), 32'd0);

      // Reset mid-request, stray memDone right after release
      resetN = 1'b0;
      #1;
      chk_reset_outputs("midRst");
      cyc(2);
      injData = 32'h00BA_DBAD;
      injReq++;
      grant(2);
      expect_pc(32'h0);
      expect_pc(32'h4);
      resetN = 1'b1;
      cyc(1);
      chk("restartReq", w1(memReq), 32'd1);
      chk("restartAddr", memAddr, 32'h0);
      cyc(12);
      chk("restartDrain", 32'(sb.size()), 32'd0);

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
